// File: rtl/stopwatch_display_pkg.sv
// Shared segment codes, time snapshot type and digit-to-segment lookup for the
// stopwatch display. Segment codes are active-high with a = bit 0, g = bit 6.
package stopwatch_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [4:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } hms_t;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_of_digit = SEG_0;
      4'd1:    seg_of_digit = SEG_1;
      4'd2:    seg_of_digit = SEG_2;
      4'd3:    seg_of_digit = SEG_3;
      4'd4:    seg_of_digit = SEG_4;
      4'd5:    seg_of_digit = SEG_5;
      4'd6:    seg_of_digit = SEG_6;
      4'd7:    seg_of_digit = SEG_7;
      4'd8:    seg_of_digit = SEG_8;
      4'd9:    seg_of_digit = SEG_9;
      default: seg_of_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd.sv
// Combinational 7-bit binary to two BCD digits; o_ovf flags values above 99,
// in which case the digit outputs are meaningless and the caller shows dashes.
module stopwatch_display_bin2bcd (
  input  logic [6:0] i_val,
  output logic       o_ovf,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [3:0] w_tens;

  // Largest t with t*10 <= i_val; saturates at 9 for the overflow range.
  always_comb begin
    w_tens = 4'd0;
    for (int t = 1; t <= 9; t++) begin
      if (i_val >= 7'(t * 10)) w_tens = 4'(t);
    end
  end

  // Remainder is below 10, so the low nibble of the difference is exact.
  assign o_ones = i_val[3:0] - 4'(w_tens * 4'd10);
  assign o_tens = w_tens;
  assign o_ovf  = (i_val > 7'd99);

endmodule

// File: rtl/stopwatch_display.sv
// Time-multiplexed HH.MM.SS 7-segment driver: frame-stable snapshot of live or
// recorded time, one digit per SCAN_DIV cycles, whole-display blink while ring.
module stopwatch_display
  import stopwatch_display_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            sec,
  input  logic [6:0]            min,
  input  logic [4:0]            hour,
  input  logic [6:0]            rec_sec,
  input  logic [6:0]            rec_min,
  input  logic [4:0]            rec_hour,
  input  logic                  show_rec,
  input  logic                  ring,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [2:0]            r_idx;
  hms_t                  r_snap;
  logic                  r_ring_s;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_phase;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  logic       w_tick;
  logic       w_snap;
  logic [6:0] w_val;
  logic       w_ovf;
  logic [3:0] w_tens;
  logic [3:0] w_ones;
  logic [6:0] w_seg_next;

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
  assign w_snap = w_tick && (r_idx == LAST_IDX);

  // Scan timing: prescaler and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
    end
  end

  // Snapshot and blink state change only at frame boundaries. The first frame
  // after ring rises counts as frame 0, so the display stays lit BLINK_DIV frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap      <= '0;
      r_ring_s    <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_snap) begin
      r_snap   <= show_rec ? hms_t'{hour: rec_hour, min: rec_min, sec: rec_sec}
                           : hms_t'{hour: hour, min: min, sec: sec};
      r_ring_s <= ring;
      if (!ring || !r_ring_s) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    case (r_idx)
      3'd0, 3'd1: w_val = r_snap.sec;
      3'd2, 3'd3: w_val = r_snap.min;
      default:    w_val = {2'b00, r_snap.hour};
    endcase
  end

  stopwatch_display_bin2bcd u_bin2bcd (
    .i_val  (w_val),
    .o_ovf  (w_ovf),
    .o_tens (w_tens),
    .o_ones (w_ones)
  );

  // Odd slots carry tens; a leading zero on the hour tens is suppressed.
  always_comb begin
    if (w_ovf)
      w_seg_next = SEG_DASH;
    else if (r_idx == LAST_IDX && w_tens == 4'd0)
      w_seg_next = SEG_BLANK;
    else
      w_seg_next = seg_of_digit(r_idx[0] ? w_tens : w_ones);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= '0;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b0;
    end else begin
      r_an  <= r_phase ? '0 : (NUM_DIGITS'(1) << r_idx);
      r_seg <= w_seg_next;
      r_dp  <= (r_idx == 3'd2) || (r_idx == 3'd4);
    end
  end

  assign seg         = ACTIVE_LOW ? ~r_seg : r_seg;
  assign dp          = ACTIVE_LOW ? ~r_dp  : r_dp;
  assign an          = ACTIVE_LOW ? ~r_an  : r_an;
  assign frame_start = w_snap && !reset;

endmodule
